// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard stall/flush controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

  // Controller states: normal issue, or front end frozen behind a mul/div.
  typedef enum logic {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  localparam int REG_W      = 5;  // register specifier width
  localparam int MD_LAT_DEF = 4;  // default mul/div occupancy of EX, in cycles

endpackage

// File: rtl/md_wait_counter.sv
// Down-counter that tracks the remaining mul/div occupancy of EX.
// Latency: load and decrement take effect on the next clk edge.
// Backpressure: none; last_o is combinational from the count (count == 1).
// Ports: clk/rst (sync, active-high), load_i + load_val_i preset the count,
//        dec_i decrements a non-zero count, last_o flags the final cycle.
module md_wait_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller: load-use bubble, taken-branch squash, mul/div freeze.
// Latency: all control outputs are combinational (Mealy) from state, count and inputs.
// Backpressure: freezes PC/IF/ID and bubbles EX/MEM for MD_LAT-1 cycles per mul/div.
// Ports: hazard inputs from ID/EX stages; write enables, flushes, Md_Done, Busy out.
// Optional macro HAZARD_STATS_EN: adds 32-bit wrapping Stall_Cnt/Flush_Cnt
// counters; when undefined both outputs are tied to zero.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_Rt,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic             Branch_Taken,
  input  logic             Md_Start,
  output logic             PC_Wr,
  output logic             IF_ID_Wr,
  output logic             ID_EX_Wr,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic             Md_Done,
  output logic             Busy,
  output logic [31:0]      Stall_Cnt,
  output logic [31:0]      Flush_Cnt
);

  state_e state_q;
  state_e state_d;
  logic   md_load;
  logic   md_dec;
  logic   md_last;
  logic   load_use;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ID_EX_MemRead && (ID_EX_Rt != '0) &&
                    ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));

  assign md_dec = (state_q == MD_WAIT) && !rst;

  md_wait_counter #(
    .CNT_W (CNT_W)
  ) u_md_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (md_load),
    .load_val_i (CNT_W'(MD_LAT - 1)),
    .dec_i      (md_dec),
    .last_o     (md_last)
  );

  always_comb begin
    PC_Wr        = 1'b1;
    IF_ID_Wr     = 1'b1;
    ID_EX_Wr     = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    Md_Done      = 1'b0;
    Busy         = 1'b0;
    md_load      = 1'b0;
    state_d      = state_q;
    if (rst) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (Branch_Taken) begin
            // Dependent ID instruction is squashed, so a load-use match is moot.
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
          end else if (Md_Start) begin
            PC_Wr        = 1'b0;
            IF_ID_Wr     = 1'b0;
            ID_EX_Wr     = 1'b0;
            EX_MEM_Flush = 1'b1;
            md_load      = 1'b1;
            state_d      = MD_WAIT;
          end else if (load_use) begin
            // One bubble suffices: next cycle the load is in MEM and forwards.
            PC_Wr       = 1'b0;
            IF_ID_Wr    = 1'b0;
            ID_EX_Flush = 1'b1;
          end
        end
        MD_WAIT: begin
          Busy = 1'b1;
          if (md_last) begin
            // Result leaves EX; a coincident Md_Start cannot be accepted here.
            Md_Done = 1'b1;
            state_d = IDLE;
          end else begin
            PC_Wr        = 1'b0;
            IF_ID_Wr     = 1'b0;
            ID_EX_Wr     = 1'b0;
            EX_MEM_Flush = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;
  logic [31:0] flush_cnt_q;
  logic [31:0] flush_cnt_d;

  // PC_Wr is forced high during rst, so reset cycles are never counted.
  assign stall_cnt_d = PC_Wr       ? stall_cnt_q : stall_cnt_q + 32'd1;
  assign flush_cnt_d = IF_ID_Flush ? flush_cnt_q + 32'd1 : flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;
`else
  assign Stall_Cnt = '0;
  assign Flush_Cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (MD_LAT=4 and MD_LAT=2 instances).
// Expected results are queued as each step is driven and popped after the
// combinational outputs settle, mid-cycle, before the next rising edge.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_rd = 1'b0;
  logic [4:0] ex_rt = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       uses_rt = 1'b0;
  logic       br = 1'b0;
  logic       md_st = 1'b0;

  logic        pc4, ifw4, idw4, iff4, idf4, exf4, dn4, bz4;
  logic        pc2, ifw2, idw2, iff2, idf2, exf2, dn2, bz2;
  logic [31:0] sc4, fc4, sc2, fc2;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MD_LAT(4), .CNT_W(5)) dut4 (
    .clk(clk), .rst(rst), .ID_EX_MemRead(mem_rd), .ID_EX_Rt(ex_rt),
    .IF_ID_Rs(id_rs), .IF_ID_Rt(id_rt), .IF_ID_UsesRt(uses_rt),
    .Branch_Taken(br), .Md_Start(md_st),
    .PC_Wr(pc4), .IF_ID_Wr(ifw4), .ID_EX_Wr(idw4), .IF_ID_Flush(iff4),
    .ID_EX_Flush(idf4), .EX_MEM_Flush(exf4), .Md_Done(dn4), .Busy(bz4),
    .Stall_Cnt(sc4), .Flush_Cnt(fc4)
  );

  hazard_stall_unit #(.MD_LAT(2), .CNT_W(5)) dut2 (
    .clk(clk), .rst(rst), .ID_EX_MemRead(mem_rd), .ID_EX_Rt(ex_rt),
    .IF_ID_Rs(id_rs), .IF_ID_Rt(id_rt), .IF_ID_UsesRt(uses_rt),
    .Branch_Taken(br), .Md_Start(md_st),
    .PC_Wr(pc2), .IF_ID_Wr(ifw2), .ID_EX_Wr(idw2), .IF_ID_Flush(iff2),
    .ID_EX_Flush(idf2), .EX_MEM_Flush(exf2), .Md_Done(dn2), .Busy(bz2),
    .Stall_Cnt(sc2), .Flush_Cnt(fc2)
  );

  // Output vector order: {PC_Wr, IF_ID_Wr, ID_EX_Wr, IF_ID_Flush,
  //                       ID_EX_Flush, EX_MEM_Flush, Md_Done, Busy}
  localparam logic [7:0] V_DEF  = 8'b1110_0000;
  localparam logic [7:0] V_LU   = 8'b0010_1000;
  localparam logic [7:0] V_BR   = 8'b1111_1000;
  localparam logic [7:0] V_MDST = 8'b0000_0100;
  localparam logic [7:0] V_MDW  = 8'b0000_0101;
  localparam logic [7:0] V_MDDN = 8'b1110_0011;

  // Observation selectors.
  localparam int K_VEC4   = 0;
  localparam int K_VEC2   = 1;
  localparam int K_STALL4 = 2;
  localparam int K_FLUSH4 = 3;
  localparam int K_STALL2 = 4;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int checks = 0;
  int passed = 0;

  // Statistics counters only count when the feature is compiled in.
  function automatic logic [31:0] st(input int n);
`ifdef HAZARD_STATS_EN
    return 32'(n);
`else
    return (n == -1) ? 32'd1 : 32'd0;
`endif
  endfunction

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_VEC4:   return {24'd0, pc4, ifw4, idw4, iff4, idf4, exf4, dn4, bz4};
      K_VEC2:   return {24'd0, pc2, ifw2, idw2, iff2, idf2, exf2, dn2, bz2};
      K_STALL4: return sc4;
      K_FLUSH4: return fc4;
      default:  return sc2;
    endcase
  endfunction

  task automatic drive(input logic r, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic b, input logic ms);
    @(negedge clk);
    rst = r; mem_rd = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
    uses_rt = ur; br = b; md_st = ms;
  endtask

  task automatic expect_val(input string tag, input int kind, input logic [31:0] e);
    sb_entry_t ent;
    ent.tag = tag; ent.kind = kind; ent.exp = e;
    sb_q.push_back(ent);
  endtask

  task automatic settle_and_check();
    sb_entry_t ent;
    logic [31:0] obs;
    #2;
    while (sb_q.size() > 0) begin
      ent = sb_q.pop_front();
      obs = observe(ent.kind);
      checks++;
      assert (obs === ent.exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", ent.tag, obs, ent.exp);
    end
  endtask

  task automatic idle_step(input logic r);
    drive(r, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with hazards present: outputs must hold their defaults.
    drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1);
    expect_val("rst_hazard_dflt4", K_VEC4, {24'd0, V_DEF});
    expect_val("rst_hazard_dflt2", K_VEC2, {24'd0, V_DEF});
    settle_and_check();
    idle_step(1'b0);
    expect_val("reset_idle", K_VEC4, {24'd0, V_DEF});
    expect_val("reset_stall_cnt", K_STALL4, st(0));
    expect_val("reset_flush_cnt", K_FLUSH4, st(0));
    settle_and_check();

    // Taken branch beats a coincident load-use match.
    drive(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
    expect_val("branch_over_lu", K_VEC4, {24'd0, V_BR});
    settle_and_check();
    idle_step(1'b0);
    expect_val("after_branch", K_VEC4, {24'd0, V_DEF});
    expect_val("branch_flush_cnt", K_FLUSH4, st(1));
    expect_val("branch_stall_cnt", K_STALL4, st(0));
    settle_and_check();

    // Load-use via rs, then release.
    drive(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
    expect_val("lu_rs", K_VEC4, {24'd0, V_LU});
    settle_and_check();
    idle_step(1'b0);
    expect_val("lu_release", K_VEC4, {24'd0, V_DEF});
    settle_and_check();
    // Load into r0 never stalls.
    drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    expect_val("lu_r0", K_VEC4, {24'd0, V_DEF});
    settle_and_check();
    // rt match ignored when ID does not read rt, honoured when it does.
    drive(1'b0, 1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0);
    expect_val("lu_rt_unused", K_VEC4, {24'd0, V_DEF});
    settle_and_check();
    drive(1'b0, 1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0);
    expect_val("lu_rt_used", K_VEC4, {24'd0, V_LU});
    settle_and_check();
    // Load without MemRead is not a hazard.
    drive(1'b0, 1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0);
    expect_val("no_memread", K_VEC4, {24'd0, V_DEF});
    expect_val("lu_stall_cnt", K_STALL4, st(2));
    settle_and_check();

    // MD_LAT=4 sequence from a clean reset; branch + load-use at t+1 ignored.
    idle_step(1'b1);
    settle_and_check();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    expect_val("md_t0", K_VEC4, {24'd0, V_MDST});
    settle_and_check();
    drive(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0);
    expect_val("md_t1_ignore_hz", K_VEC4, {24'd0, V_MDW});
    expect_val("md_t1_flush_cnt", K_FLUSH4, st(0));
    settle_and_check();
    idle_step(1'b0);
    expect_val("md_t2", K_VEC4, {24'd0, V_MDW});
    settle_and_check();
    idle_step(1'b0);
    expect_val("md_t3_done", K_VEC4, {24'd0, V_MDDN});
    settle_and_check();
    idle_step(1'b0);
    expect_val("md_t4_idle", K_VEC4, {24'd0, V_DEF});
    expect_val("md_stall_cnt", K_STALL4, st(3));
    expect_val("md_flush_cnt", K_FLUSH4, st(0));
    settle_and_check();

    // Reset aborts MD_WAIT: no Md_Done afterwards, counters cleared.
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    expect_val("abort_t0", K_VEC4, {24'd0, V_MDST});
    settle_and_check();
    idle_step(1'b1);
    expect_val("abort_in_rst", K_VEC4, {24'd0, V_DEF});
    settle_and_check();
    idle_step(1'b0);
    expect_val("abort_t2_idle", K_VEC4, {24'd0, V_DEF});
    expect_val("abort_stall_cnt", K_STALL4, st(0));
    settle_and_check();
    idle_step(1'b0);
    expect_val("abort_t3_no_done", K_VEC4, {24'd0, V_DEF});
    settle_and_check();

    // MD_LAT=2: one stall, Md_Done next; Md_Start in the done cycle ignored.
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    expect_val("lat2_t0", K_VEC2, {24'd0, V_MDST});
    settle_and_check();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    expect_val("lat2_t1_done", K_VEC2, {24'd0, V_MDDN});
    expect_val("lat4_t1_wait", K_VEC4, {24'd0, V_MDW});
    settle_and_check();
    idle_step(1'b0);
    expect_val("lat2_t2_not_busy", K_VEC2, {24'd0, V_DEF});
    expect_val("lat2_stall_cnt", K_STALL2, st(1));
    settle_and_check();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
